gem_resync_ctrl: RTL
====================

Name: gem_resync_ctrl

Overview:
- Automatic recovery sequencer for the GEM fiber receive path. Sits downstream of the GEM sync monitor and consumes its per-chamber and super-chamber sync flags plus the per-fiber link_good.
- Debounces persistent desync, then pulses a receiver/deframer reset for the affected chamber's fiber pair. Waits for the link to settle and retries up to a limit before declaring sticky failure.
- Status outputs feed the VME status registers.

Parameters:
- DEBOUNCE_CNT, 8: consecutive faulty cycles required before a reset is issued (1..255).
- RESET_WIDTH, 4: rx_reset pulse width in cycles (1..255).
- SETTLE_CNT, 16: post-reset blanking cycles; also the clean-run length that clears retry_count (1..255).
- MAX_RETRY, 3: resets allowed before FAILED (1..15).

Ports:
- clock  in  1  40 MHz fabric clock
- global_reset  in  1  synchronous, active-high reset
- enable  in  1  auto-recovery enable (VME bit)
- ttc_resync  in  1  TTC resync; clears recovery status
- link_good  in  4  per-fiber link OK; [1:0] chamber A, [3:2] chamber B
- gemA_synced  in  1  chamber A fibers mutually synced
- gemB_synced  in  1  chamber B fibers mutually synced
- gems_synced  in  1  super-chamber synced
- rx_reset  out  2  reset request; bit0 = chamber A fibers, bit1 = chamber B fibers
- recovering  out  1  high in DEBOUNCE, RESET or SETTLE
- recovery_failed  out  1  sticky failure flag
- retry_count  out  4  resets issued since last clean period
- state  out  3  FSM state encoding, for debug
- gemA_errcnt, gemB_errcnt, gems_errcnt  out  16 each  desync event counters (optional feature)

Behaviour:
- All outputs are registered. On reset: rx_reset = 0, recovering = 0, recovery_failed = 0, retry_count = 0, state = IDLE, errcnts = 0.
- Fault terms:
  - faultA = ~gemA_synced | ~&link_good[1:0]
  - faultB = ~gemB_synced | ~&link_good[3:2]
  - faultS = ~gems_synced
  - fault = faultA | faultB | faultS
- Priority, highest first: global_reset > ttc_resync > ~enable > FSM.
  - ttc_resync: state forced to IDLE next cycle; retry_count, recovery_failed and rx_reset are cleared.
  - ~enable: state forced to IDLE; rx_reset deasserts next cycle; retry_count and recovery_failed are held.
- States and encoding:
  - IDLE = 0: go to MONITOR when enable.
  - MONITOR = 1: if fault, go to DEBOUNCE, load cnt = DEBOUNCE_CNT-1, mask = {faultB, faultA}. Otherwise count clean cycles; after SETTLE_CNT consecutive clean cycles, retry_count is cleared.
  - DEBOUNCE = 2: each cycle, mask |= {faultB, faultA}. Any clean cycle returns to MONITOR with no retry consumed. When cnt == 0 and fault is still present, go to RESET. If mask == 0 (super-chamber-only fault), mask becomes 2'b11. cnt decrements each cycle.
  - RESET = 3: rx_reset = mask for exactly RESET_WIDTH cycles. retry_count increments on entry and saturates at 15. Then go to SETTLE.
  - SETTLE = 4: faults are ignored for SETTLE_CNT cycles. On exit: if fault and retry_count ≥ MAX_RETRY, go to FAILED; otherwise go to MONITOR.
  - FAILED = 5: recovery_failed = 1, rx_reset = 0. Exit only via ttc_resync or global_reset (or ~enable to IDLE, with the flag held).
- Latency: fault first sampled in MONITOR at cycle N → DEBOUNCE at N+1 → rx_reset first high at N+1+DEBOUNCE_CNT.
- A fault that clears on the last DEBOUNCE cycle issues no reset.

Optional Feature:
- GEM_RESYNC_ERRCNT_EN defined: gemA_errcnt, gemB_errcnt and gems_errcnt each increment on the rising edge of faultA, faultB and faultS respectively, independent of FSM state.
  - Counters saturate at 16'hFFFF.
  - Cleared by global_reset or ttc_resync.
- Undefined: these outputs are tied to 0 and no counter logic is built.

Decomposition:
- Shared gem package holds:
  - state encoding constants: IDLE … FAILED
  - chamber mask bit indices: CHAMBER_A = 0, CHAMBER_B = 1
  - fiber-to-chamber mapping constants
- One sub-module, gem_sat_cnt: parameterised saturating counter with clear. Used for the error counters and retry_count.

Test Plan (defaults unless stated):
- Clean links, enable = 1 for 100 cycles → state = 1, rx_reset = 0, retry_count = 0.
- gemA_synced = 0 held; first sampled in MONITOR at cycle N → rx_reset = 2'b01 during cycles N+9..N+12, retry_count = 1, recovering = 1 through SETTLE.
- gemB_synced = 0 for 7 cycles only → no rx_reset, back to MONITOR, retry_count unchanged.
- gems_synced = 0 alone, persistent → rx_reset = 2'b11. After 3 resets with the fault persisting → state = 5, recovery_failed = 1. ttc_resync pulse → state = 0 then 1, recovery_failed = 0, retry_count = 0.
- One reset, then 16 clean cycles in MONITOR → retry_count returns to 0.
- enable dropped mid-RESET → rx_reset = 0 the next cycle, state = 0. With GEM_RESYNC_ERRCNT_EN defined, three faultA pulses → gemA_errcnt = 3.

Source files
------------

// File: rtl/gem_resync_ctrl_pkg.sv
// Shared constants for the GEM resync controller: FSM state encoding,
// chamber mask bit positions and fiber-to-chamber mapping.
package gem_resync_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MONITOR  = 3'd1;
    localparam logic [2:0] ST_DEBOUNCE = 3'd2;
    localparam logic [2:0] ST_RESET    = 3'd3;
    localparam logic [2:0] ST_SETTLE   = 3'd4;
    localparam logic [2:0] ST_FAILED   = 3'd5;

    localparam int CHAMBER_A = 0;
    localparam int CHAMBER_B = 1;

    // link_good[1:0] belong to chamber A, link_good[3:2] to chamber B
    localparam int FIBER_A_LO = 0;
    localparam int FIBER_A_HI = 1;
    localparam int FIBER_B_LO = 2;
    localparam int FIBER_B_HI = 3;

    function automatic logic is_recovering(input logic [2:0] st);
        return (st == ST_DEBOUNCE) || (st == ST_RESET) || (st == ST_SETTLE);
    endfunction

endpackage

// File: rtl/gem_resync_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous reset and synchronous clear;
// clear wins over increment.
module gem_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             srst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/gem_resync_ctrl.sv
// GEM fiber receive auto-recovery sequencer: debounces desync, pulses rx_reset
// for the faulty chamber(s), settles and retries. GEM_RESYNC_ERRCNT_EN adds desync event counters.
module gem_resync_ctrl
    import gem_resync_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 8,
    parameter int RESET_WIDTH  = 4,
    parameter int SETTLE_CNT   = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clock,
    input  logic        global_reset,
    input  logic        enable,
    input  logic        ttc_resync,
    input  logic [3:0]  link_good,
    input  logic        gemA_synced,
    input  logic        gemB_synced,
    input  logic        gems_synced,
    output logic [1:0]  rx_reset,
    output logic        recovering,
    output logic        recovery_failed,
    output logic [3:0]  retry_count,
    output logic [2:0]  state,
    output logic [15:0] gemA_errcnt,
    output logic [15:0] gemB_errcnt,
    output logic [15:0] gems_errcnt
);

    localparam logic [7:0] DEB_LOAD    = 8'(DEBOUNCE_CNT - 1);
    localparam logic [7:0] RST_LOAD    = 8'(RESET_WIDTH - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CNT - 1);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    logic       fault_a, fault_b, fault_s, fault;
    logic [1:0] fault_vec, mask_acc, reset_mask;

    logic [2:0] state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] clean_reg, clean_next;
    logic [1:0] mask_reg, mask_next;
    logic [1:0] rx_reset_reg, rx_reset_next;
    logic       recovering_reg;
    logic       failed_reg, failed_next;
    logic       retry_inc, retry_clr;

    assign fault_a = ~gemA_synced | ~&link_good[FIBER_A_HI:FIBER_A_LO];
    assign fault_b = ~gemB_synced | ~&link_good[FIBER_B_HI:FIBER_B_LO];
    assign fault_s = ~gems_synced;
    assign fault   = fault_a | fault_b | fault_s;

    assign fault_vec[CHAMBER_A] = fault_a;
    assign fault_vec[CHAMBER_B] = fault_b;
    assign mask_acc   = mask_reg | fault_vec;
    // A super-chamber-only fault cannot be attributed, so both chambers are reset
    assign reset_mask = (mask_acc == 2'b00) ? 2'b11 : mask_acc;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        clean_next    = clean_reg;
        mask_next     = mask_reg;
        rx_reset_next = rx_reset_reg;
        failed_next   = failed_reg;
        retry_inc     = 1'b0;
        retry_clr     = 1'b0;
        if (ttc_resync) begin
            state_next    = ST_IDLE;
            rx_reset_next = 2'b00;
            failed_next   = 1'b0;
            retry_clr     = 1'b1;
        end else if (!enable) begin
            state_next    = ST_IDLE;
            rx_reset_next = 2'b00;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_MONITOR;
                    clean_next = '0;
                end
                ST_MONITOR: begin
                    if (fault) begin
                        state_next = ST_DEBOUNCE;
                        cnt_next   = DEB_LOAD;
                        mask_next  = fault_vec;
                    end else if (clean_reg == SETTLE_LOAD) begin
                        retry_clr = 1'b1;
                    end else begin
                        clean_next = clean_reg + 8'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    mask_next = mask_acc;
                    if (!fault) begin
                        state_next = ST_MONITOR;
                        clean_next = '0;
                    end else if (cnt_reg == 8'd0) begin
                        state_next    = ST_RESET;
                        mask_next     = reset_mask;
                        rx_reset_next = reset_mask;
                        cnt_next      = RST_LOAD;
                        retry_inc     = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                end
                ST_RESET: begin
                    if (cnt_reg == 8'd0) begin
                        state_next    = ST_SETTLE;
                        rx_reset_next = 2'b00;
                        cnt_next      = SETTLE_LOAD;
                    end else begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg != 8'd0) begin
                        cnt_next = cnt_reg - 8'd1;
                    end else if (fault && (retry_count >= RETRY_LIMIT)) begin
                        state_next  = ST_FAILED;
                        failed_next = 1'b1;
                    end else begin
                        state_next = ST_MONITOR;
                        clean_next = '0;
                    end
                end
                ST_FAILED: begin
                    rx_reset_next = 2'b00;
                    failed_next   = 1'b1;
                end
                default: begin
                    state_next    = ST_IDLE;
                    rx_reset_next = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (global_reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            clean_reg      <= '0;
            mask_reg       <= '0;
            rx_reset_reg   <= '0;
            recovering_reg <= 1'b0;
            failed_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            clean_reg      <= clean_next;
            mask_reg       <= mask_next;
            rx_reset_reg   <= rx_reset_next;
            recovering_reg <= is_recovering(state_next);
            failed_reg     <= failed_next;
        end
    end

    gem_sat_cnt #(.WIDTH(4)) u_retry_cnt (
        .clock (clock),
        .srst  (global_reset),
        .clear (retry_clr),
        .inc   (retry_inc),
        .count (retry_count)
    );

    assign state           = state_reg;
    assign rx_reset        = rx_reset_reg;
    assign recovering      = recovering_reg;
    assign recovery_failed = failed_reg;

`ifdef GEM_RESYNC_ERRCNT_EN
    logic [2:0]  fault_all;
    logic [2:0]  fault_prev_reg;
    logic [15:0] errcnt [3];

    assign fault_all = {fault_s, fault_b, fault_a};

    always_ff @(posedge clock) begin
        if (global_reset) begin
            fault_prev_reg <= '0;
        end else begin
            fault_prev_reg <= fault_all;
        end
    end

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_errcnt
        gem_sat_cnt #(.WIDTH(16)) u_errcnt (
            .clock (clock),
            .srst  (global_reset),
            .clear (ttc_resync),
            .inc   (fault_all[gi] & ~fault_prev_reg[gi]),
            .count (errcnt[gi])
        );
    end

    assign gemA_errcnt = errcnt[0];
    assign gemB_errcnt = errcnt[1];
    assign gems_errcnt = errcnt[2];
`else
    assign gemA_errcnt = '0;
    assign gemB_errcnt = '0;
    assign gems_errcnt = '0;
`endif

endmodule
